// File: rtl/rtc_poll_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rtc_poll_scheduler_pkg
// Description : RTC time-register addresses and poll-sequencer state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package rtc_poll_scheduler_pkg;

  localparam logic [7:0] ADDR_SEG  = 8'h21;
  localparam logic [7:0] ADDR_MIN  = 8'h22;
  localparam logic [7:0] ADDR_HORA = 8'h23;
  localparam logic [7:0] ADDR_DIA  = 8'h24;
  localparam logic [7:0] ADDR_MES  = 8'h25;
  localparam logic [7:0] ADDR_ANIO = 8'h26;

  localparam int unsigned NUM_REGS = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/rtc_bcd_check.sv
`default_nettype none
// ============================================================================
// Module      : rtc_bcd_check
// Description : Flags whether a byte holds two valid BCD digits.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_bcd_check (
  input  logic [7:0] i_byte,
  output logic       o_valid
);

  assign o_valid = (i_byte[7:4] <= 4'd9) && (i_byte[3:0] <= 4'd9);

endmodule
`default_nettype wire

// File: rtl/rtc_poll_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rtc_poll_scheduler
// Description : Periodically reads the six RTC time registers and commits them
//               as one validated BCD snapshot.
// Revision    : 1.0 - initial release
// ============================================================================
module rtc_poll_scheduler
  import rtc_poll_scheduler_pkg::*;
#(
  parameter int unsigned POLL_CYCLES    = 5_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [7:0]  BASE_ADDR      = ADDR_SEG
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       hold,
  output logic       rd_req,
  output logic [7:0] dir_out,
  input  logic       rd_done,
  input  logic [7:0] rd_data,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio,
  output logic       snap_valid,
  output logic       bcd_err,
  output logic       timeout_err
);

  localparam int c_tmr_w = $clog2(POLL_CYCLES + 1);
  localparam int c_to_w  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_tmr_w-1:0] c_tmr_reload = c_tmr_w'(POLL_CYCLES - 1);
  localparam logic [c_to_w-1:0]  c_to_last    = c_to_w'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]         c_last_idx   = 3'(NUM_REGS - 1);

  state_t               state_q, state_d;
  logic [c_tmr_w-1:0]   timer_q, timer_d;
  logic [c_to_w-1:0]    to_cnt_q, to_cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic                 sweep_err_q, sweep_err_d;
  logic [7:0]           shadow_q [NUM_REGS];
  logic [7:0]           shadow_d [NUM_REGS];
  logic [7:0]           snap_q   [NUM_REGS];
  logic [7:0]           snap_d   [NUM_REGS];
  logic                 rd_req_q, rd_req_d;
  logic [7:0]           dir_out_q, dir_out_d;
  logic                 snap_valid_q, snap_valid_d;
  logic                 bcd_err_q, bcd_err_d;
  logic                 timeout_err_q, timeout_err_d;
  logic                 w_byte_ok;

  rtc_bcd_check u_bcd_check (
    .i_byte  (rd_data),
    .o_valid (w_byte_ok)
  );

  always_comb begin
    state_d       = state_q;
    // Timer free-runs down in every state so the period is fixed by the reload.
    timer_d       = (timer_q != '0) ? timer_q - c_tmr_w'(1) : timer_q;
    to_cnt_d      = to_cnt_q;
    idx_d         = idx_q;
    sweep_err_d   = sweep_err_q;
    shadow_d      = shadow_q;
    snap_d        = snap_q;
    rd_req_d      = rd_req_q;
    dir_out_d     = dir_out_q;
    snap_valid_d  = 1'b0;
    bcd_err_d     = bcd_err_q;
    timeout_err_d = timeout_err_q;

    case (state_q)
      ST_IDLE: begin
        if ((timer_q == '0) && en) begin
          state_d     = ST_ISSUE;
          idx_d       = 3'd0;
          sweep_err_d = 1'b0;
          timer_d     = c_tmr_reload;
        end
      end
      ST_ISSUE: begin
        state_d   = ST_WAIT;
        rd_req_d  = 1'b1;
        dir_out_d = BASE_ADDR + 8'(idx_q);
        to_cnt_d  = '0;
      end
      ST_WAIT: begin
        // A response arriving on the last allowed cycle still counts.
        if (rd_done) begin
          rd_req_d         = 1'b0;
          shadow_d[idx_q]  = rd_data;
          if (!w_byte_ok) begin
            sweep_err_d = 1'b1;
          end
          if (!en) begin
            state_d = ST_IDLE;
          end else if (idx_q == c_last_idx) begin
            state_d = ST_COMMIT;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_ISSUE;
          end
        end else if (to_cnt_q == c_to_last) begin
          rd_req_d      = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + c_to_w'(1);
        end
      end
      ST_COMMIT: begin
        if (!hold) begin
          if (sweep_err_q) begin
            bcd_err_d = 1'b1;
          end else begin
            snap_d        = shadow_q;
            snap_valid_d  = 1'b1;
            bcd_err_d     = 1'b0;
            timeout_err_d = 1'b0;
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      timer_q       <= '0;
      to_cnt_q      <= '0;
      idx_q         <= 3'd0;
      sweep_err_q   <= 1'b0;
      rd_req_q      <= 1'b0;
      dir_out_q     <= 8'h00;
      snap_valid_q  <= 1'b0;
      bcd_err_q     <= 1'b0;
      timeout_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= 8'h00;
        snap_q[i]   <= 8'h00;
      end
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      to_cnt_q      <= to_cnt_d;
      idx_q         <= idx_d;
      sweep_err_q   <= sweep_err_d;
      rd_req_q      <= rd_req_d;
      dir_out_q     <= dir_out_d;
      snap_valid_q  <= snap_valid_d;
      bcd_err_q     <= bcd_err_d;
      timeout_err_q <= timeout_err_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= shadow_d[i];
        snap_q[i]   <= snap_d[i];
      end
    end
  end

  assign rd_req      = rd_req_q;
  assign dir_out     = dir_out_q;
  assign seg         = snap_q[0];
  assign min         = snap_q[1];
  assign hora        = snap_q[2];
  assign dia         = snap_q[3];
  assign mes         = snap_q[4];
  assign anio        = snap_q[5];
  assign snap_valid  = snap_valid_q;
  assign bcd_err     = bcd_err_q;
  assign timeout_err = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_rtc_poll_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_rtc_poll_scheduler
// Description : Randomized bench with a behavioural RTC controller and a
//               sweep-outcome reference model for rtc_poll_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rtc_poll_scheduler;

  localparam int POLL = 200;
  localparam int TMO  = 1024;
  localparam int BASE = 'h21;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       hold;
  logic       rd_req;
  logic [7:0] dir_out;
  logic       rd_done;
  logic [7:0] rd_data;
  logic [7:0] seg, min, hora, dia, mes, anio;
  logic       snap_valid, bcd_err, timeout_err;

  logic [7:0] resp_mem [6];
  int         mute_idx = -1;
  int         latency  = 20;
  int         answers, timeouts_seen, hi_len;
  int         req_log[$];
  int         start_log[$];
  int         cyc = 0;
  int         snap_cnt = 0;
  bit         rst_abort = 1'b0;

  logic [7:0] snap_m [6];
  bit         bcd_m, to_m;
  int         n_vec = 0;
  int         n_err = 0;

  rtc_poll_scheduler #(
    .POLL_CYCLES    (POLL),
    .TIMEOUT_CYCLES (TMO),
    .BASE_ADDR      (8'h21)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .hold        (hold),
    .rd_req      (rd_req),
    .dir_out     (dir_out),
    .rd_done     (rd_done),
    .rd_data     (rd_data),
    .seg         (seg),
    .min         (min),
    .hora        (hora),
    .dia         (dia),
    .mes         (mes),
    .anio        (anio),
    .snap_valid  (snap_valid),
    .bcd_err     (bcd_err),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (snap_valid === 1'b1) snap_cnt <= snap_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // RTC controller: answers each request after 'latency' cycles, or never for mute_idx.
  initial begin : p_responder
    int a, ai, hi;
    rd_done = 1'b0;
    rd_data = 8'h00;
    forever begin
      @(negedge clk);
      if (rd_req === 1'b1) begin
        a  = int'(dir_out);
        ai = a - BASE;
        req_log.push_back(a);
        if (a == BASE) start_log.push_back(cyc);
        if (ai == mute_idx) begin
          hi = 0;
          while (rd_req === 1'b1 && hi < 4 * TMO) begin
            hi++;
            @(negedge clk);
          end
          hi_len = hi;
          timeouts_seen++;
        end else begin
          repeat (latency - 1) @(negedge clk);
          if (!rst_abort) chk("dir_stable", dir_out, a);
          rd_done = 1'b1;
          rd_data = (ai >= 0 && ai < 6) ? resp_mem[ai] : 8'hff;
          @(negedge clk);
          rd_done = 1'b0;
          rd_data = 8'($urandom);
          if (!rst_abort) chk("rd_req_drop", rd_req, 0);
          answers++;
        end
      end
    end
  end

  task automatic gen_data(input int kind);
    int k;
    mute_idx = -1;
    for (int i = 0; i < 6; i++) resp_mem[i] = 8'(($urandom % 10) * 16 + ($urandom % 10));
    if (kind == 1) begin
      k = $urandom_range(0, 5);
      if ($urandom % 2 == 0) resp_mem[k] = 8'($urandom_range(10, 15) * 16 + ($urandom % 16));
      else                   resp_mem[k] = 8'(($urandom % 16) * 16 + $urandom_range(10, 15));
    end else if (kind == 2) begin
      mute_idx = $urandom_range(0, 5);
    end
  endtask

  task automatic check_outputs(input string where);
    logic [7:0] obs [6];
    obs[0] = seg; obs[1] = min; obs[2] = hora;
    obs[3] = dia; obs[4] = mes; obs[5] = anio;
    for (int i = 0; i < 6; i++) chk($sformatf("%s_out%0d", where, i), obs[i], snap_m[i]);
    chk({where, "_bcd_err"}, bcd_err, bcd_m);
    chk({where, "_timeout_err"}, timeout_err, to_m);
  endtask

  task automatic run_sweep(input bit use_hold, input int hold_len);
    int n_req, bound, held;
    bit bad;
    bad = 1'b0;
    for (int i = 0; i < 6; i++)
      if ((resp_mem[i] / 16) > 9 || (resp_mem[i] % 16) > 9) bad = 1'b1;
    n_req = (mute_idx >= 0) ? mute_idx + 1 : 6;
    req_log.delete();
    answers       = 0;
    timeouts_seen = 0;
    bound         = 0;
    hold          = use_hold;
    en            = 1'b1;
    if (mute_idx >= 0) begin
      while (timeouts_seen == 0 && bound < 5000) begin tick(); bound++; end
      en   = 1'b0;
      hold = 1'b0;
      chk("timeout_seen", timeouts_seen, 1);
      chk("timeout_len", hi_len, TMO);
      chk("timeout_rd_req", rd_req, 0);
      to_m = 1'b1;
    end else begin
      while (answers < 6 && bound < 5000) begin tick(); bound++; end
      chk("answers", answers, 6);
      if (use_hold) begin
        held = 0;
        repeat (hold_len) begin
          tick();
          if (snap_valid !== 1'b0) held++;
        end
        chk("held_snap", held, 0);
        hold = 1'b0;
      end
      tick();
      chk("snap_valid", snap_valid, bad ? 0 : 1);
      en = 1'b0;
      if (bad) begin
        bcd_m = 1'b1;
      end else begin
        for (int i = 0; i < 6; i++) snap_m[i] = resp_mem[i];
        bcd_m = 1'b0;
        to_m  = 1'b0;
      end
    end
    chk("req_count", req_log.size(), n_req);
    for (int i = 0; i < req_log.size() && i < n_req; i++) chk("dir_seq", req_log[i], BASE + i);
    tick();
    chk("snap_pulse_len", snap_valid, 0);
    check_outputs("sweep");
  endtask

  initial begin : p_main
    int bound, sc0, off, t0, r;
    reset = 1'b0;
    en    = 1'b0;
    hold  = 1'b0;
    for (int i = 0; i < 6; i++) snap_m[i] = 8'h00;
    bcd_m = 1'b0;
    to_m  = 1'b0;
    repeat (3) tick();
    check_outputs("reset");
    chk("reset_rd_req", rd_req, 0);
    chk("reset_dir_out", dir_out, 0);
    chk("reset_snap_valid", snap_valid, 0);
    reset = 1'b1;
    repeat (5) tick();
    chk("idle_no_req", rd_req, 0);

    // Directed clean sweep with fixed register contents.
    latency  = 20;
    mute_idx = -1;
    resp_mem = '{8'h45, 8'h30, 8'h12, 8'h19, 8'h10, 8'h16};
    sc0 = snap_cnt;
    run_sweep(1'b0, 0);
    chk("first_snap_count", snap_cnt - sc0, 1);

    // Non-BCD minutes, then a clean sweep clears the error.
    resp_mem = '{8'h45, 8'h3A, 8'h12, 8'h19, 8'h10, 8'h16};
    run_sweep(1'b0, 0);
    gen_data(0);
    run_sweep(1'b0, 0);

    // Silent hours register, then the next sweep restarts from seconds.
    gen_data(0);
    mute_idx = 2;
    run_sweep(1'b0, 0);
    gen_data(0);
    run_sweep(1'b0, 0);

    // Commit deferred by hold.
    gen_data(0);
    run_sweep(1'b1, 25);

    for (int it = 0; it < 10; it++) begin
      r       = $urandom % 8;
      latency = $urandom_range(1, 20);
      gen_data(r < 5 ? 0 : (r < 7 ? 1 : 2));
      if ($urandom % 3 == 0) run_sweep(1'b1, $urandom_range(1, 30));
      else                   run_sweep(1'b0, 0);
    end

    // Asynchronous reset while a request is outstanding.
    gen_data(0);
    latency = 20;
    req_log.delete();
    en    = 1'b1;
    bound = 0;
    while (!(req_log.size() >= 3 && rd_req === 1'b1) && bound < 2000) begin tick(); bound++; end
    chk("rst_reach_wait", rd_req, 1);
    rst_abort = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("rst_async_rd_req", rd_req, 0);
    chk("rst_async_dir_out", dir_out, 0);
    chk("rst_async_snap_valid", snap_valid, 0);
    for (int i = 0; i < 6; i++) snap_m[i] = 8'h00;
    bcd_m = 1'b0;
    to_m  = 1'b0;
    check_outputs("async_reset");
    en = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (40) tick();
    rst_abort = 1'b0;

    // Sweep period with a shortened poll interval.
    gen_data(0);
    latency = 20;
    start_log.delete();
    sc0 = snap_cnt;
    en  = 1'b1;
    t0  = cyc;
    repeat (1000) tick();
    en = 1'b0;
    repeat (60) tick();
    chk("period_starts", start_log.size(), 5);
    off = (start_log.size() > 0) ? start_log[0] - t0 : -1;
    chk("first_start_offset", (off >= 1 && off <= 3), 1);
    for (int i = 1; i < start_log.size(); i++) chk("period", start_log[i] - start_log[i-1], POLL);
    chk("period_snaps", snap_cnt - sc0, 5);
    for (int i = 0; i < 6; i++) snap_m[i] = resp_mem[i];
    check_outputs("period");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
